// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types, encodings and burst helpers for the burst master.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_BURST,
    ST_LASTDATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Beats per command; anything other than a fixed-length INCR runs as one beat.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      INCR4:   return 5'd4;
      INCR8:   return 5'd8;
      INCR16:  return 5'd16;
      default: return 5'd1;
    endcase
  endfunction

  // Hburst value actually driven on the bus: unsupported encodings collapse to SINGLE.
  function automatic logic [2:0] burst_code(input logic [2:0] hburst);
    return (burst_beats(hburst) == 5'd1) ? SINGLE : hburst;
  endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// Address generator: holds the current beat address and the beats still to issue.
// Latency: new address visible the cycle after load_i/advance_i.
// Backpressure: advances only when the owner reports an accepted address phase.
module ahb_addr_gen
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        burst_i,
  input  logic [2:0]        size_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_beat_o
);

  logic [ADDR_W-1:0] addr_q, addr_d, next_addr;
  logic [4:0]        beats_left_q, beats_left_d;

  // Increment wraps modulo 2^ADDR_W; the caller keeps bursts inside a 1KB page.
  assign next_addr   = addr_q + (ADDR_W'(1) << size_i);
  assign last_beat_o = (beats_left_q == 5'd1);
  assign addr_o      = addr_q;

  // Load on command accept, step on every accepted non-final address phase.
  always_comb begin
    addr_d       = addr_q;
    beats_left_d = beats_left_q;
    if (load_i) begin
      addr_d       = addr_i;
      beats_left_d = burst_beats(burst_i);
    end else if (advance_i && !last_beat_o) begin
      addr_d       = next_addr;
      beats_left_d = beats_left_q - 5'd1;
    end
  end

  // Address and beat counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q       <= '0;
      beats_left_q <= '0;
    end else begin
      addr_q       <= addr_d;
      beats_left_q <= beats_left_d;
    end
  end

endmodule

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: turns one command plus a write-data stream into pipelined AHB beats.
// Latency: NONSEQ one cycle after cmd handshake; rd_valid/done one cycle after the last data phase.
// Backpressure: Hreadyout stalls address/data phases; missing write data inserts IDLE (first) or BUSY.
module ahb_burst_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_size,
  input  logic [2:0]        cmd_burst,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              done_err,
  output logic [ADDR_W-1:0] Haddr,
  output logic [1:0]        Htrans,
  output logic              Hwrite,
  output logic [2:0]        Hsize,
  output logic [2:0]        Hburst,
  output logic [DATA_W-1:0] Hwdata,
  output logic              Hreadyin,
  input  logic              Hreadyout,
  input  logic [1:0]        Hresp,
  input  logic [DATA_W-1:0] Hrdata
);

  state_e            state_q, state_d;
  htrans_e           htrans;
  logic              write_q;
  logic [2:0]        size_q, burst_q;
  logic              dphase_q, dphase_d;
  logic [DATA_W-1:0] wdata_q, rd_data_q;
  logic              rd_valid_q, done_q, done_err_q;
  logic              cmd_fire, accept, last_beat;
  logic              dphase_active, dphase_done, err_first;
  logic [ADDR_W-1:0] addr;

  // done and a fresh cmd_ready never share a cycle.
  assign cmd_ready = (state_q == ST_IDLE) && !done_q;
  assign cmd_fire  = cmd_valid && cmd_ready;

  assign accept        = ((htrans == NONSEQ) || (htrans == SEQ)) && Hreadyout;
  assign dphase_active = ((state_q == ST_BURST) && dphase_q) || (state_q == ST_LASTDATA);
  assign dphase_done   = dphase_active && Hreadyout;
  assign err_first     = dphase_active && !Hreadyout && (Hresp == ERROR);

  ahb_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk_i       (Hclk),
    .rst_ni      (Hresetn),
    .load_i      (cmd_fire),
    .addr_i      (cmd_addr),
    .burst_i     (cmd_burst),
    .size_i      (size_q),
    .advance_i   (accept),
    .addr_o      (addr),
    .last_beat_o (last_beat)
  );

  // State register.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: step through address phases, drain the last data phase, or unwind an error.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (cmd_fire) state_d = ST_ADDR;
      ST_ADDR:     if (accept) state_d = last_beat ? ST_LASTDATA : ST_BURST;
      ST_BURST: begin
        if (err_first)               state_d = ST_ERR1;
        else if (accept && last_beat) state_d = ST_LASTDATA;
      end
      ST_LASTDATA: begin
        if (err_first)      state_d = ST_ERR1;
        else if (Hreadyout) state_d = ST_IDLE;
      end
      ST_ERR1:     if (Hreadyout) state_d = ST_ERR2;
      ST_ERR2:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Bus outputs: write beats only go out (and pop data) once a data word is on offer.
  always_comb begin
    htrans   = IDLE;
    wd_ready = 1'b0;
    case (state_q)
      ST_ADDR: begin
        if (!write_q || wd_valid) begin
          htrans   = NONSEQ;
          wd_ready = write_q && Hreadyout;
        end
      end
      ST_BURST: begin
        if (!write_q || wd_valid) begin
          htrans   = SEQ;
          wd_ready = write_q && Hreadyout;
        end else begin
          htrans = BUSY;
        end
      end
      default: begin
        htrans   = IDLE;
        wd_ready = 1'b0;
      end
    endcase
  end

  // A data phase opens after an accepted address phase and closes on the next ready cycle.
  always_comb begin
    dphase_d = dphase_q;
    if (accept)         dphase_d = 1'b1;
    else if (Hreadyout) dphase_d = 1'b0;
  end

  // Command latch, write holding register, registered read return and completion pulses.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      write_q    <= 1'b0;
      size_q     <= '0;
      burst_q    <= '0;
      dphase_q   <= 1'b0;
      wdata_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      dphase_q <= dphase_d;
      if (cmd_fire) begin
        write_q <= cmd_write;
        size_q  <= cmd_size;
        burst_q <= burst_code(cmd_burst);
      end
      if (wd_ready) wdata_q <= wd_data;
      rd_valid_q <= dphase_done && !write_q;
      if (dphase_done && !write_q) rd_data_q <= Hrdata;
      done_q     <= ((state_q == ST_LASTDATA) && Hreadyout) ||
                    ((state_q == ST_ERR1) && Hreadyout);
      done_err_q <= (state_q == ST_ERR1) && Hreadyout;
    end
  end

  assign Haddr    = addr;
  assign Htrans   = htrans;
  assign Hwrite   = write_q;
  assign Hsize    = size_q;
  assign Hburst   = burst_q;
  assign Hwdata   = wdata_q;
  assign Hreadyin = Hreadyout;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign done     = done_q;
  assign done_err = done_err_q;

endmodule
